// File: rtl/cen_gen_pkg.sv
// Shared constants for the clock-enable generator.
// Default emulator ratios against the 24 MHz clk_sys.
package cen_gen_pkg;
  localparam int CEN_VIDEO_NUM = 1;
  localparam int CEN_VIDEO_DEN = 4;
  localparam int CEN_CPU_NUM   = 1;
  localparam int CEN_CPU_DEN   = 12;
endpackage

// File: rtl/cen_gen_ch.sv
// One fractional enable channel: ratio, accumulator, step credit.
// Ports: wr/num_w/den_w load ratio; sync/pause/step gate; cen pulse, credit_nxt.
module cen_gen_ch #(
  parameter int ACC_W   = 16,
  parameter int DEF_NUM = 1,
  parameter int DEF_DEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [ACC_W-1:0] num_w,
  input  logic [ACC_W-1:0] den_w,
  input  logic             sync,
  input  logic             pause,
  input  logic             step,
  output logic             cen,
  output logic             credit_nxt
);
  logic [ACC_W-1:0] num;
  logic [ACC_W-1:0] den;
  logic [ACC_W:0]   acc;
  logic [ACC_W:0]   sum;
  logic             credit;
  logic             live;
  logic             go;
  logic             fire;

  assign live = (num != '0) && (den != '0);
  assign go   = live && !(pause && !credit) && !wr && !sync;
  assign sum  = acc + {1'b0, num};
  assign fire = sum >= {1'b0, den};

  // A credit is only granted from zero, so a repeated step cannot stack.
  always_comb begin
    credit_nxt = credit;
    if (!pause)
      credit_nxt = 1'b0;
    else if (credit)
      credit_nxt = live && !(go && fire);
    else
      credit_nxt = step && live;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num    <= ACC_W'(DEF_NUM);
      den    <= ACC_W'(DEF_DEN);
      acc    <= '0;
      credit <= 1'b0;
      cen    <= 1'b0;
    end else begin
      credit <= credit_nxt;
      if (wr) begin
        num <= (num_w > den_w) ? den_w : num_w;
        den <= den_w;
        acc <= '0;
        cen <= 1'b0;
      end else if (sync) begin
        acc <= '0;
        cen <= 1'b0;
      end else if (go) begin
        acc <= fire ? sum - {1'b0, den} : sum;
        cen <= fire;
      end else begin
        cen <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/cen_gen.sv
// Multi-channel fractional clock-enable generator with pause/step.
// Ports: cfg_* write one channel ratio; sync/pause/step; cen pulses, halted.
module cen_gen
  import cen_gen_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 16,
  parameter int DEF_NUM  = CEN_VIDEO_NUM,
  parameter int DEF_DEN  = CEN_VIDEO_DEN,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  input  logic                sync,
  input  logic                pause,
  input  logic                step,
  output logic [CHANNELS-1:0] cen,
  output logic                halted
);
  logic [1:0]          rst_q;
  logic                rst_sync_n;
  logic [CHANNELS-1:0] credit_nxt;

  // Assert asynchronously, release through two flops.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      rst_q <= 2'b00;
    else
      rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_sync_n = rst_q[1];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr;
    assign wr = cfg_wr && (cfg_ch == CH_W'(i));

    cen_gen_ch #(
      .ACC_W   (ACC_W),
      .DEF_NUM (DEF_NUM),
      .DEF_DEN (DEF_DEN)
    ) u_ch (
      .clk        (clk_sys),
      .rst_n      (rst_sync_n),
      .wr         (wr),
      .num_w      (cfg_num),
      .den_w      (cfg_den),
      .sync       (sync),
      .pause      (pause),
      .step       (step),
      .cen        (cen[i]),
      .credit_nxt (credit_nxt[i])
    );
  end

  always_ff @(posedge clk_sys or negedge rst_sync_n) begin
    if (!rst_sync_n)
      halted <= 1'b0;
    else
      halted <= pause & ~|credit_nxt;
  end
endmodule

// File: tb/tb_cen_gen.sv
// Directed bench for cen_gen.
// Hand-computed pulse counts and phases per scenario.
module tb_cen_gen;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        cfg_wr  = 1'b0;
  logic [1:0]  cfg_ch  = '0;
  logic [15:0] cfg_num = '0;
  logic [15:0] cfg_den = '0;
  logic        sync    = 1'b0;
  logic        pause   = 1'b0;
  logic        step    = 1'b0;
  logic [3:0]  cen;
  logic        halted;

  int n_chk = 0;
  int n_err = 0;
  int cnt[4];
  int first[4];
  int mixed;

  always #5 clk_sys = ~clk_sys;

  cen_gen dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .cfg_wr  (cfg_wr),
    .cfg_ch  (cfg_ch),
    .cfg_num (cfg_num),
    .cfg_den (cfg_den),
    .sync    (sync),
    .pause   (pause),
    .step    (step),
    .cen     (cen),
    .halted  (halted)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_cfg(input logic [1:0] ch, input logic [15:0] n,
                        input logic [15:0] d);
    cfg_wr  = 1'b1;
    cfg_ch  = ch;
    cfg_num = n;
    cfg_den = d;
    tick();
    cfg_wr  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < 4; c++) begin
      cnt[c]   = 0;
      first[c] = -1;
    end
    mixed = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      for (int c = 0; c < 4; c++)
        if (cen[c]) begin
          cnt[c]++;
          if (first[c] < 0) first[c] = i;
        end
      if (cen != 4'h0 && cen != 4'hf) mixed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int last, mn, mx, c0, c1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_cen", 32'(cen), 0);
    check("rst_halted", 32'(halted), 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    tick();

    run(40);
    for (int c = 0; c < 4; c++) check("def_cnt", cnt[c], 10);
    check("def_first", first[0], 3);
    check("def_phase", mixed, 0);

    wr_cfg(2'd1, 16'd3, 16'd8);
    check("wr_cen1", 32'(cen[1]), 0);
    last = -1; mn = 99; mx = 0; c0 = 0; c1 = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (cen[0]) c0++;
      if (cen[1]) begin
        c1++;
        if (last >= 0) begin
          if (i - last < mn) mn = i - last;
          if (i - last > mx) mx = i - last;
        end
        last = i;
      end
    end
    check("frac_cnt", c1, 300);
    check("frac_gap_min", mn, 2);
    check("frac_gap_max", mx, 3);
    check("other_ch_cnt", c0, 200);

    wr_cfg(2'd2, 16'd9, 16'd5);
    check("clamp_wr_cen", 32'(cen[2]), 0);
    wr_cfg(2'd3, 16'd1, 16'd0);
    check("clamp_first", 32'(cen[2]), 1);
    run(20);
    check("clamp_cnt", cnt[2], 20);
    check("disable_cnt", cnt[3], 0);

    wr_cfg(2'd1, 16'd1, 16'd4);
    wr_cfg(2'd2, 16'd1, 16'd4);
    wr_cfg(2'd3, 16'd1, 16'd4);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_cen", 32'(cen), 0);

    pause = 1'b1;
    tick();
    check("pause_cen", 32'(cen), 0);
    check("pause_halted", 32'(halted), 1);
    run(3);
    check("paused_quiet", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);

    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_credit", 32'(halted), 0);
    run(8);
    for (int c = 0; c < 4; c++) check("step_cnt", cnt[c], 1);
    check("step_first", first[0], 3);
    check("step_phase", mixed, 0);
    check("step_halted", 32'(halted), 1);

    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    run(10);
    check("dbl_step_cnt0", cnt[0], 1);
    check("dbl_step_cnt3", cnt[3], 1);
    check("dbl_step_first", first[0], 1);
    check("dbl_step_halted", 32'(halted), 1);

    pause = 1'b0;
    tick();
    check("release_halted", 32'(halted), 0);
    run(7);
    check("resume_cnt", cnt[0], 2);
    check("resume_first", first[0], 2);

    tick();
    tick();
    sync    = 1'b1;
    cfg_wr  = 1'b1;
    cfg_ch  = 2'd1;
    cfg_num = 16'd1;
    cfg_den = 16'd2;
    tick();
    sync   = 1'b0;
    cfg_wr = 1'b0;
    check("sync_wr_cen", 32'(cen), 0);
    run(6);
    check("sync_ch0_first", first[0], 3);
    check("sync_ch1_first", first[1], 1);
    check("sync_ch1_cnt", cnt[1], 3);
    check("sync_ch2_first", first[2], 3);

    pause = 1'b1;
    sync  = 1'b1;
    tick();
    sync = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    check("step_ch1_only", 32'(cen), 2);
    #2 reset_n = 1'b0;
    #1;
    check("async_cen", 32'(cen), 0);
    check("async_halted", 32'(halted), 0);
    pause = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    run(8);
    for (int c = 0; c < 4; c++) check("post_rst_cnt", cnt[c], 2);
    check("post_rst_first", first[1], 3);
    check("post_rst_phase", mixed, 0);
    check("post_rst_halted", 32'(halted), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
